// File: rtl/vga_text_seq_if.sv
// Bundle between the sequencer and its environment: VS stream, buffer/config writes, drawer outputs.
// No latency of its own; pure wiring.
// No backpressure; all strobes are single-cycle and always accepted.
interface vga_text_seq_if;
  logic [25:0] strRGB_i;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        cfg_we;
  logic [4:0]  cfg_len;
  logic [2:0]  cfg_color;
  logic [2:0]  cfg_zoom;
  logic [9:0]  cfg_x;
  logic [9:0]  cfg_y;
  logic        start;
  logic        stop;
  logic [7:0]  character;
  logic [2:0]  color;
  logic [2:0]  zoom;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        busy;
  logic        frame_tick;

  modport master (
    output strRGB_i, wr_en, wr_addr, wr_data, cfg_we, cfg_len, cfg_color, cfg_zoom,
           cfg_x, cfg_y, start, stop,
    input  character, color, zoom, x_pos, y_pos, busy, frame_tick
  );

  modport slave (
    input  strRGB_i, wr_en, wr_addr, wr_data, cfg_we, cfg_len, cfg_color, cfg_zoom,
           cfg_x, cfg_y, start, stop,
    output character, color, zoom, x_pos, y_pos, busy, frame_tick
  );
endinterface

// File: rtl/vga_text_seq.sv
// Steps a character drawer through a 16-entry string, one character per HOLD_FRAMES video frames.
// Latency: drawer outputs update exactly one px_clk after the VS rising-edge (frame boundary) cycle.
// No backpressure: writes, config and start/stop pulses are accepted every cycle.
module vga_text_seq #(
  parameter int HOLD_FRAMES = 30,
  parameter bit LOOP        = 1'b1
) (
  input logic          px_clk,
  input logic          rst_n,
  vga_text_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, SHOW} state_t;

  state_t      state, state_nxt;
  logic        vs_d;
  logic        fb;
  logic [7:0]  mem [16];
  logic [4:0]  sh_len;
  logic [2:0]  sh_color;
  logic [2:0]  sh_zoom;
  logic [9:0]  sh_x;
  logic [9:0]  sh_y;
  logic [3:0]  idx;
  logic [9:0]  fcnt;
  logic        stop_pend;
  logic [4:0]  len_eff;
  logic [3:0]  last_idx;
  logic        stop_req;
  logic        hold_done;
  logic        at_last;
  logic        do_commit;
  logic        do_adv;
  logic        do_idle;
  logic        do_load;
  logic [3:0]  rd_idx;
  logic        unused_rgb;

  // Only VS (bit 1) matters; the rest of the pixel stream is deliberately ignored.
  assign unused_rgb = ^{bus.strRGB_i[25:2], bus.strRGB_i[0]};

  assign fb        = bus.strRGB_i[1] & ~vs_d;
  assign stop_req  = stop_pend | bus.stop;
  assign hold_done = (fcnt == 10'(HOLD_FRAMES - 1));
  assign last_idx  = 4'(len_eff - 5'd1);
  assign at_last   = (idx == last_idx);

  // Clamp the programmed length into 1..16.
  always_comb begin
    len_eff = sh_len;
    if (sh_len == 5'd0)       len_eff = 5'd1;
    else if (sh_len > 5'd16)  len_eff = 5'd16;
  end

  // State register.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; stop always wins over start, and only acts on a frame boundary once armed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop) state_nxt = ARM;
      ARM:     if (fb) state_nxt = stop_req ? IDLE : SHOW;
      SHOW:    if (fb && (stop_req || (hold_done && at_last && !LOOP))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-cycle actions derived from state; they steer the registered datapath below.
  always_comb begin
    do_commit = (state == ARM) && fb && !stop_req;
    do_adv    = (state == SHOW) && fb && !stop_req && hold_done;
    do_idle   = (state != IDLE) && (state_nxt == IDLE);
    do_load   = (do_commit || do_adv) && !do_idle;
    rd_idx    = (do_commit || at_last) ? 4'd0 : idx + 4'd1;
  end

  // Character buffer: never reset, contents are whatever was last written.
  always_ff @(posedge px_clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Shadow configuration, picked up by the drawer only at commit or advance.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_len   <= 5'd1;
      sh_color <= 3'd0;
      sh_zoom  <= 3'd0;
      sh_x     <= 10'd0;
      sh_y     <= 10'd0;
    end else if (bus.cfg_we) begin
      sh_len   <= bus.cfg_len;
      sh_color <= bus.cfg_color;
      sh_zoom  <= bus.cfg_zoom;
      sh_x     <= bus.cfg_x;
      sh_y     <= bus.cfg_y;
    end
  end

  // Sequencing counters, frame detection and registered drawer outputs.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d           <= 1'b1;
      bus.frame_tick <= 1'b0;
      bus.busy       <= 1'b0;
      stop_pend      <= 1'b0;
      idx            <= 4'd0;
      fcnt           <= 10'd0;
      bus.character  <= 8'h20;
      bus.color      <= 3'd0;
      bus.zoom       <= 3'd0;
      bus.x_pos      <= 10'd0;
      bus.y_pos      <= 10'd0;
    end else begin
      vs_d           <= bus.strRGB_i[1];
      bus.frame_tick <= fb;
      bus.busy       <= (state_nxt != IDLE);
      if (state_nxt == IDLE) stop_pend <= 1'b0;
      else if (bus.stop)     stop_pend <= 1'b1;
      if (do_commit)                    fcnt <= 10'd0;
      else if (state == SHOW && fb)     fcnt <= hold_done ? 10'd0 : fcnt + 10'd1;
      if (do_load) idx <= rd_idx;
      if (do_idle) begin
        // Zoom and position are left as they were so the drawer does not jump.
        bus.character <= 8'h20;
        bus.color     <= 3'd0;
      end else if (do_load) begin
        bus.character <= mem[rd_idx];
        bus.color     <= sh_color;
        bus.zoom      <= sh_zoom;
        bus.x_pos     <= sh_x;
        bus.y_pos     <= sh_y;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_seq.sv
// Directed bench: one looping and one single-pass sequencer share the same stimulus.
// Expected values are hand-derived with HOLD_FRAMES=2.
// Frame boundaries are created by raising VS for one cycle.
module tb_vga_text_seq;
  logic px_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 px_clk = ~px_clk;

  vga_text_seq_if bl();
  vga_text_seq_if bn();

  vga_text_seq #(.HOLD_FRAMES(2), .LOOP(1'b1)) u_loop (.px_clk(px_clk), .rst_n(rst_n), .bus(bl));
  vga_text_seq #(.HOLD_FRAMES(2), .LOOP(1'b0)) u_once (.px_clk(px_clk), .rst_n(rst_n), .bus(bn));

  assign bn.strRGB_i  = bl.strRGB_i;
  assign bn.wr_en     = bl.wr_en;
  assign bn.wr_addr   = bl.wr_addr;
  assign bn.wr_data   = bl.wr_data;
  assign bn.cfg_we    = bl.cfg_we;
  assign bn.cfg_len   = bl.cfg_len;
  assign bn.cfg_color = bl.cfg_color;
  assign bn.cfg_zoom  = bl.cfg_zoom;
  assign bn.cfg_x     = bl.cfg_x;
  assign bn.cfg_y     = bl.cfg_y;
  assign bn.start     = bl.start;
  assign bn.stop      = bl.stop;

  int n_cmp = 0;
  int n_err = 0;
  int ticks = 0;
  int t0;

  always @(negedge px_clk) if (bl.frame_tick) ticks = ticks + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic frame();
    bl.strRGB_i[1] = 1'b1;
    tick();
    bl.strRGB_i[1] = 1'b0;
    tick();
    tick();
  endtask

  // Frame boundary with a buffer write landing on the very same edge.
  task automatic frame_wr(input logic [3:0] a, input logic [7:0] d);
    bl.strRGB_i[1] = 1'b1;
    bl.wr_en = 1'b1; bl.wr_addr = a; bl.wr_data = d;
    tick();
    bl.wr_en = 1'b0;
    bl.strRGB_i[1] = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bl.wr_en = 1'b1; bl.wr_addr = a; bl.wr_data = d;
    tick();
    bl.wr_en = 1'b0;
  endtask

  task automatic cfg(input logic [4:0] len, input logic [2:0] c, input logic [2:0] z,
                     input logic [9:0] x, input logic [9:0] y);
    bl.cfg_we = 1'b1; bl.cfg_len = len; bl.cfg_color = c; bl.cfg_zoom = z;
    bl.cfg_x = x; bl.cfg_y = y;
    tick();
    bl.cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p);
    bl.start = s; bl.stop = p;
    tick();
    bl.start = 1'b0; bl.stop = 1'b0;
  endtask

  logic [7:0] exp_l [6];
  logic [7:0] exp_n [4];

  initial begin
    exp_l = '{8'h48, 8'h48, 8'h49, 8'h49, 8'h48, 8'h48};
    exp_n = '{8'h48, 8'h48, 8'h49, 8'h49};
    bl.strRGB_i = '0; bl.wr_en = 0; bl.wr_addr = 0; bl.wr_data = 0;
    bl.cfg_we = 0; bl.cfg_len = 0; bl.cfg_color = 0; bl.cfg_zoom = 0;
    bl.cfg_x = 0; bl.cfg_y = 0; bl.start = 0; bl.stop = 0;
    tick(); tick();
    check("rst_char",  32'(bl.character), 32'h20);
    check("rst_color", 32'(bl.color), 32'h0);
    check("rst_zoom",  32'(bl.zoom), 32'h0);
    check("rst_x",     32'(bl.x_pos), 32'h0);
    check("rst_y",     32'(bl.y_pos), 32'h0);
    check("rst_busy",  32'(bl.busy), 32'h0);
    check("rst_tick",  32'(bl.frame_tick), 32'h0);
    rst_n = 1'b1;
    tick();

    // "HI", length 2, color 2, zoom 1 at (100,50)
    wr(4'd0, 8'h48); wr(4'd1, 8'h49);
    cfg(5'd2, 3'd2, 3'd1, 10'd100, 10'd50);
    pulse(1'b1, 1'b0);
    check("arm_busy_l", 32'(bl.busy), 32'h1);
    check("arm_busy_n", 32'(bn.busy), 32'h1);
    check("arm_char",   32'(bl.character), 32'h20);
    t0 = ticks;
    frame();
    check("fb1_char",  32'(bl.character), 32'h48);
    check("fb1_color", 32'(bl.color), 32'h2);
    check("fb1_zoom",  32'(bl.zoom), 32'h1);
    check("fb1_x",     32'(bl.x_pos), 32'd100);
    check("fb1_y",     32'(bl.y_pos), 32'd50);
    check("fb1_char_n", 32'(bn.character), 32'h48);
    for (int k = 1; k < 6; k++) begin
      frame();
      check("loop_seq", 32'(bl.character), 32'(exp_l[k]));
      if (k < 4) check("once_seq", 32'(bn.character), 32'(exp_n[k]));
      if (k == 4) begin
        check("once_end_busy",  32'(bn.busy), 32'h0);
        check("once_end_char",  32'(bn.character), 32'h20);
        check("once_end_color", 32'(bn.color), 32'h0);
        check("once_end_x",     32'(bn.x_pos), 32'd100);
        check("once_end_zoom",  32'(bn.zoom), 32'h1);
      end
    end
    check("tick_count", 32'(ticks - t0), 32'd6);

    // Stop mid-SHOW is pending until the next frame boundary
    pulse(1'b0, 1'b1);
    check("stop_pend_busy", 32'(bl.busy), 32'h1);
    frame();
    check("stop_busy",  32'(bl.busy), 32'h0);
    check("stop_char",  32'(bl.character), 32'h20);
    check("stop_color", 32'(bl.color), 32'h0);
    check("stop_x",     32'(bl.x_pos), 32'd100);

    // Start and stop together in IDLE
    pulse(1'b1, 1'b1);
    check("ss_busy_l", 32'(bl.busy), 32'h0);
    check("ss_busy_n", 32'(bn.busy), 32'h0);
    frame();
    check("ss_char", 32'(bl.character), 32'h20);

    // Shadow updates only at advance; buffer writes do not disturb the shown character
    pulse(1'b1, 1'b0);
    frame();
    check("sh_a_char", 32'(bl.character), 32'h48);
    cfg(5'd2, 3'd5, 3'd1, 10'd200, 10'd50);
    frame();
    check("sh_b_x",     32'(bl.x_pos), 32'd100);
    check("sh_b_color", 32'(bl.color), 32'h2);
    frame();
    check("sh_c_char",  32'(bl.character), 32'h49);
    check("sh_c_x",     32'(bl.x_pos), 32'd200);
    check("sh_c_color", 32'(bl.color), 32'h5);
    wr(4'd1, 8'h5A);
    check("wr_shown", 32'(bl.character), 32'h49);
    frame();
    check("sh_d_char", 32'(bl.character), 32'h49);
    frame();
    check("sh_e_char", 32'(bl.character), 32'h48);
    check("sh_e_busy_n", 32'(bn.busy), 32'h0);
    frame();
    frame_wr(4'd1, 8'h77);
    check("same_edge_old", 32'(bl.character), 32'h5A);
    frame();
    check("sh_h_char", 32'(bl.character), 32'h5A);
    frame();
    check("sh_i_char", 32'(bl.character), 32'h48);
    pulse(1'b0, 1'b1);
    frame();
    check("sh_stop_busy", 32'(bl.busy), 32'h0);

    // Length 0 behaves as length 1
    wr(4'd0, 8'h41); wr(4'd1, 8'h42);
    cfg(5'd0, 3'd3, 3'd0, 10'd10, 10'd20);
    pulse(1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      frame();
      check("len0_char", 32'(bl.character), 32'h41);
      if (j == 2) check("len0_busy_n", 32'(bn.busy), 32'h0);
    end
    pulse(1'b0, 1'b1);
    frame();

    // Length 20 clamps to 16
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h60 + i));
    cfg(5'd20, 3'd1, 3'd0, 10'd0, 10'd0);
    pulse(1'b1, 1'b0);
    for (int j = 0; j < 33; j++) begin
      frame();
      check("len20_char", 32'(bl.character), 32'h60 + ((j / 2) % 16));
      if (j == 32) check("len20_busy_n", 32'(bn.busy), 32'h0);
    end
    pulse(1'b0, 1'b1);
    frame();

    // Asynchronous reset mid-SHOW, then VS held high through release
    cfg(5'd2, 3'd4, 3'd2, 10'd300, 10'd60);
    pulse(1'b1, 1'b0);
    frame();
    check("pre_rst_x", 32'(bl.x_pos), 32'd300);
    rst_n = 1'b0;
    #1;
    check("arst_char",  32'(bl.character), 32'h20);
    check("arst_busy",  32'(bl.busy), 32'h0);
    check("arst_x",     32'(bl.x_pos), 32'h0);
    check("arst_color", 32'(bl.color), 32'h0);
    check("arst_zoom",  32'(bl.zoom), 32'h0);
    check("arst_busy_n", 32'(bn.busy), 32'h0);
    bl.strRGB_i[1] = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    t0 = ticks;
    repeat (4) tick();
    check("vs_high_no_tick", 32'(ticks - t0), 32'd0);
    check("vs_high_busy",    32'(bl.busy), 32'h0);
    bl.strRGB_i[1] = 1'b0;
    tick();
    bl.strRGB_i[1] = 1'b1;
    tick(); tick();
    check("vs_rise_tick", 32'(ticks - t0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
